// File: rtl/uart_rx_oversampler_if.sv
// Stream handshake carrying received words out of the UART receiver.
// The master drives data and valid, and the slave answers with ready.
interface uart_rx_oversampler_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_rx_oversampler.sv
// UART receiver that oversamples the line with a programmable divider and takes each bit at mid-bit.
// A single held output word is offered downstream, with per-frame parity, framing and overrun pulses.
module uart_rx_oversampler #(
  parameter int DATA_WIDTH    = 8,
  parameter int DIVIDER_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     uart_rx_i,
  input  logic [DIVIDER_WIDTH-1:0] clk_divider_i,
  input  logic                     parity_odd_i,
  input  logic                     parity_even_i,
  uart_rx_oversampler_if.master    m_axis,
  output logic                     parity_err_o,
  output logic                     frame_err_o,
  output logic                     overrun_err_o,
  output logic                     busy_o
);

  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);
  localparam logic [DIVIDER_WIDTH-1:0] MIN_DIV = DIVIDER_WIDTH'(4);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                   state_q, state_d;
  logic                     sync1_q, sync2_q;
  logic [DIVIDER_WIDTH-1:0] cnt_q;
  logic [DIVIDER_WIDTH-1:0] div_q;
  logic                     parity_en_q;
  logic                     parity_odd_q;
  logic                     par_err_q;
  logic [BIT_W-1:0]         bit_idx_q;
  logic [DATA_WIDTH-1:0]    shift_q;

  logic rx_s;
  logic sample;
  logic bit_end;
  logic start;
  logic complete;

  assign rx_s   = sync2_q;
  assign busy_o = (state_q != IDLE);

  // The synchronizer resets to the idle level, so the line never looks like a start bit coming out of reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      sync1_q <= uart_rx_i;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d  = state_q;
    start    = 1'b0;
    complete = 1'b0;
    sample   = (state_q != IDLE) && (cnt_q == (div_q >> 1));
    bit_end  = (state_q != IDLE) && (cnt_q == div_q - DIVIDER_WIDTH'(1));
    unique case (state_q)
      IDLE: begin
        if (!rx_s && clk_divider_i >= MIN_DIV) begin
          state_d = START;
          start   = 1'b1;
        end
      end
      START: begin
        if (sample && rx_s) state_d = IDLE;
        else if (bit_end)   state_d = DATA;
      end
      DATA: begin
        if (bit_end && bit_idx_q == LAST_BIT) state_d = parity_en_q ? PARITY : STOP;
      end
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (sample) begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The frame settings are latched at the start edge, so input changes mid-frame only affect the next frame.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q        <= '0;
      div_q        <= '0;
      parity_en_q  <= 1'b0;
      parity_odd_q <= 1'b0;
      par_err_q    <= 1'b0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
    end else begin
      if (start) begin
        cnt_q        <= '0;
        div_q        <= clk_divider_i;
        parity_en_q  <= parity_odd_i | parity_even_i;
        parity_odd_q <= parity_odd_i;
        par_err_q    <= 1'b0;
        bit_idx_q    <= '0;
      end else if (state_q != IDLE) begin
        cnt_q <= bit_end ? '0 : cnt_q + DIVIDER_WIDTH'(1);
      end
      if (state_q == DATA && sample) shift_q <= {rx_s, shift_q[DATA_WIDTH-1:1]};
      if (state_q == DATA && bit_end) bit_idx_q <= bit_idx_q + BIT_W'(1);
      if (state_q == PARITY && sample) par_err_q <= (rx_s != ((^shift_q) ^ parity_odd_q));
    end
  end

  // Output register: a completed word loads only when the slot is free or being drained this cycle.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      m_axis.tdata  <= '0;
      m_axis.tvalid <= 1'b0;
      parity_err_o  <= 1'b0;
      frame_err_o   <= 1'b0;
      overrun_err_o <= 1'b0;
    end else begin
      parity_err_o  <= complete & par_err_q;
      frame_err_o   <= complete & ~rx_s;
      overrun_err_o <= complete & m_axis.tvalid & ~m_axis.tready;
      if (complete && (!m_axis.tvalid || m_axis.tready)) begin
        m_axis.tdata  <= shift_q;
        m_axis.tvalid <= 1'b1;
      end else if (m_axis.tready) begin
        m_axis.tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx_oversampler.md
UART_RX_OVERSAMPLER -- requirements
Module: uart_rx_oversampler

Interface
REQ-001 Parameter DATA_WIDTH, default 8, payload bits per frame (5..9).
REQ-002 Parameter DIVIDER_WIDTH, default 16, width of clk_divider_i.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 clk_i  input  1  system clock; all state advances on its rising edge.
REQ-005 rstn_i  input  1  asynchronous active-low reset.
REQ-006 uart_rx_i  input  1  asynchronous serial line; idle high.
REQ-007 clk_divider_i  input  DIVIDER_WIDTH  clock cycles per bit (D).
REQ-008 parity_odd_i  input  1  odd parity enable.
REQ-009 parity_even_i  input  1  even parity enable.
REQ-010 m_axis_tdata  output  DATA_WIDTH  received word, LSB first on line.
REQ-011 m_axis_tvalid  output  1  word available.
REQ-012 m_axis_tready  input  1  downstream (RX FIFO) accepts word.
REQ-013 parity_err_o  output  1  one-cycle pulse: parity mismatch on completed frame.
REQ-014 frame_err_o  output  1  one-cycle pulse: stop bit sampled low.
REQ-015 overrun_err_o  output  1  one-cycle pulse: word dropped, output register occupied.
REQ-016 busy_o  output  1  high whenever state is not IDLE.

Function
REQ-017 uart_rx_i SHALL pass a 2-FF synchronizer (reset value 1); all line decisions use the synchronized value.
REQ-018 FSM states IDLE, START, DATA, PARITY, STOP; parity enabled (P=1) when either parity input is high; both high SHALL behave as odd.
REQ-019 IDLE -> START on the first cycle T with the synchronized line low; in that cycle, latch D and parity mode, clear bit counter, set cnt=0.
REQ-020 cnt SHALL increment every cycle outside IDLE; a bit is sampled at cnt==D/2 (floor); at cnt==D-1, cnt wraps to 0 and the state/bit index advances.
REQ-021 START: if the sample at T+D/2 is high, return to IDLE next cycle (glitch), no output, no error.
REQ-022 DATA: bit k sampled at T+(k+1)*D+D/2, shifted in LSB first; after DATA_WIDTH bits go to PARITY if P=1, else STOP.
REQ-023 PARITY: the sampled bit is compared to XOR of data (even) or its inverse (odd); a mismatch is recorded for this frame.
REQ-024 STOP: at the stop sample (T+(1+DATA_WIDTH+P)*D+D/2), the word completes and the FSM returns to IDLE next cycle without waiting for the bit end.
REQ-025 On completion: if m_axis_tvalid==0 or m_axis_tready==1 in that cycle, load tdata and assert tvalid next cycle; otherwise drop the word, keep the held word, pulse overrun_err_o.
REQ-026 parity_err_o and frame_err_o SHALL pulse in the cycle after completion; a word with a parity or frame error is still delivered.
REQ-027 m_axis_tvalid SHALL remain high, tdata stable, until a cycle with tready high; it then clears unless a new word loads that same cycle.
REQ-028 D<4 SHALL hold the FSM in IDLE; changes to clk_divider_i/parity inputs mid-frame SHALL NOT affect the current frame.

Reset
REQ-029 While rstn_i is low: state IDLE, cnt 0, synchronizer 1, tdata 0, tvalid 0, all error pulses 0, busy_o 0; a frame in progress is discarded.
REQ-030 After rstn_i deasserts, a line already low SHALL be treated as a start edge once synchronized.

Verification
REQ-031 D=16, no parity, send 0xA5 with stop=1, tready=1 -> tdata=0xA5, tvalid for exactly 1 cycle, 155 clk edges after first edge sampling line low; no error pulses.
REQ-032 D=16, even parity, send 0x03 with parity bit 1 -> tdata=0x03 delivered, parity_err_o pulses once; with parity bit 0 -> no pulse.
REQ-033 D=16, send 0x5A with stop=0 -> tdata=0x5A delivered, frame_err_o pulses once.
REQ-034 tready=0, send 0x11 then 0x22 -> tdata stays 0x11, overrun_err_o pulses at second completion; tready=1 -> 0x11 consumed, tvalid drops.
REQ-035 Low pulse on uart_rx_i of 4 cycles at D=16 -> no tvalid, no errors, busy_o returns low after 9 cycles in START.
REQ-036 rstn_i asserted mid-DATA of 0xFF frame -> outputs reset immediately; next clean frame 0x3C received correctly.
